// File: rtl/hci_core_stride_issuer_pkg.sv
// hci_core_stride_issuer_pkg: shared state and configuration types for the strided HCI issuer
package hci_core_stride_issuer_pkg;

    localparam int unsigned HCI_AW    = 32;
    localparam int unsigned HCI_CNT_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} hci_stride_state_e;

    typedef struct packed {
        logic [HCI_AW-1:0]    base;
        logic [HCI_AW-1:0]    stride;
        logic [HCI_CNT_W-1:0] count;
        logic                 wen;
    } hci_stride_cfg_t;

endpackage

// File: rtl/hci_core_stride_issuer_if.sv
// hci_core_stride_issuer_if: wide HCI core request/response channel
interface hci_core_stride_issuer_if #(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 32,
    parameter int unsigned BW = 8
);

    logic             req;
    logic [AW-1:0]    add;
    logic             wen;
    logic [DW/BW-1:0] be;
    logic [DW-1:0]    data;
    logic             gnt;
    logic             r_valid;
    logic [DW-1:0]    r_data;

    modport master (output req, add, wen, be, data, input gnt, r_valid, r_data);
    modport slave  (input req, add, wen, be, data, output gnt, r_valid, r_data);

endinterface

// File: rtl/hci_core_stride_issuer_outstanding_counter.sv
// hci_outstanding_counter: saturating up/down count of granted-but-unanswered requests
module hci_outstanding_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic restart_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;

    assign full_o  = cnt_q == W'(MAX);
    assign empty_o = cnt_q == '0;

    // simultaneous inc/dec leaves the count unchanged; both ends saturate
    always_ff @(posedge clk_i) begin
        if (clear_i || restart_i) cnt_q <= '0;
        else if (inc_i && !dec_i && !full_o) cnt_q <= cnt_q + W'(1);
        else if (dec_i && !inc_i && !empty_o) cnt_q <= cnt_q - W'(1);
    end

endmodule

// File: rtl/hci_core_stride_issuer.sv
// hci_core_stride_issuer: issues base+k*stride HCI requests; optional stall counter via HCI_STRIDE_ISSUER_PERF_EN
module hci_core_stride_issuer
    import hci_core_stride_issuer_pkg::*;
#(
    parameter int unsigned DW        = 128,
    parameter int unsigned AW        = HCI_AW,
    parameter int unsigned BW        = 8,
    parameter int unsigned CNT_W     = HCI_CNT_W,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                        clk_i,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [AW-1:0]               cfg_base_i,
    input  logic [AW-1:0]               cfg_stride_i,
    input  logic [CNT_W-1:0]            cfg_count_i,
    input  logic                        cfg_wen_i,
    input  logic [DW-1:0]               wdata_i,
    input  logic [DW/BW-1:0]            wbe_i,
    input  logic                        wdata_valid_i,
    output logic                        wdata_ready_o,
    hci_core_stride_issuer_if.master    tcdm,
    output logic [DW-1:0]               rdata_o,
    output logic                        rvalid_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CNT_W-1:0]            perf_stall_o
);

    hci_stride_state_e state_q, state_d;
    hci_stride_cfg_t   cfg_q;
    logic [CNT_W-1:0]  issue_cnt_q, resp_cnt_q;
    logic              launch, fire, last_grant, resp, full, empty;

    assign launch     = state_q == IDLE && start_i;
    assign fire       = tcdm.req && tcdm.gnt;
    assign last_grant = fire && issue_cnt_q + CNT_W'(1) == cfg_q.count;
    assign resp       = tcdm.r_valid && busy_o;

    assign tcdm.req  = state_q == ISSUE && !full && (cfg_q.wen || wdata_valid_i);
    assign tcdm.add  = cfg_q.base & ~AW'(3);
    assign tcdm.wen  = cfg_q.wen;
    assign tcdm.be   = wbe_i;
    assign tcdm.data = wdata_i;

    assign wdata_ready_o = fire && !cfg_q.wen;
    assign busy_o        = state_q == ISSUE || state_q == DRAIN;
    assign done_o        = state_q == DONE;
    assign rvalid_o      = resp && cfg_q.wen;
    assign rdata_o       = tcdm.r_data;

    hci_outstanding_counter #(.MAX(MAX_OUTST)) i_outst (
        .clk_i    (clk_i),
        .clear_i  (clear_i),
        .restart_i(launch),
        .inc_i    (fire),
        .dec_i    (resp),
        .full_o   (full),
        .empty_o  (empty)
    );

    // sequence control: issue until the last grant, then wait for every response
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = cfg_count_i != '0 ? ISSUE : DONE;
            ISSUE:   if (last_grant) state_d = DRAIN;
            DRAIN:   if (resp_cnt_q == cfg_q.count && empty) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // state, latched config and progress counters; cfg_q.base advances as the running address
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                cfg_q       <= '{base: cfg_base_i, stride: cfg_stride_i, count: cfg_count_i, wen: cfg_wen_i};
                issue_cnt_q <= '0;
                resp_cnt_q  <= '0;
            end else begin
                if (fire) begin
                    cfg_q.base  <= cfg_q.base + cfg_q.stride;
                    issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                end
                if (resp) resp_cnt_q <= resp_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef HCI_STRIDE_ISSUER_PERF_EN
    logic [CNT_W-1:0] perf_q;

    // count issue cycles lost to grant wait or to the outstanding limit, saturating
    always_ff @(posedge clk_i) begin
        if (clear_i || launch) perf_q <= '0;
        else if (state_q == ISSUE && ((tcdm.req && !tcdm.gnt) || (!tcdm.req && full)) && perf_q != '1)
            perf_q <= perf_q + CNT_W'(1);
    end

    assign perf_stall_o = perf_q;
`else
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_hci_core_stride_issuer.sv
// tb_hci_core_stride_issuer: randomized check of the strided issuer against a transaction-level model
module tb_hci_core_stride_issuer;

    localparam int DW = 128, AW = 32, BW = 8, BEW = DW / BW, CNT_W = 16, MO = 2;
    localparam int NEVER = 1 << 30;
`ifdef HCI_STRIDE_ISSUER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             clear_i, start_i, cfg_wen_i, wdata_valid_i;
    logic             wdata_ready_o, rvalid_o, busy_o, done_o;
    logic [AW-1:0]    cfg_base_i, cfg_stride_i;
    logic [CNT_W-1:0] cfg_count_i, perf_stall_o;
    logic [DW-1:0]    wdata_i, rdata_o;
    logic [BEW-1:0]   wbe_i;

    hci_core_stride_issuer_if #(.DW(DW), .AW(AW), .BW(BW)) tcdm ();

    hci_core_stride_issuer #(.DW(DW), .AW(AW), .BW(BW), .CNT_W(CNT_W), .MAX_OUTST(MO)) dut (
        .clk_i        (clk_i),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .cfg_base_i   (cfg_base_i),
        .cfg_stride_i (cfg_stride_i),
        .cfg_count_i  (cfg_count_i),
        .cfg_wen_i    (cfg_wen_i),
        .wdata_i      (wdata_i),
        .wbe_i        (wbe_i),
        .wdata_valid_i(wdata_valid_i),
        .wdata_ready_o(wdata_ready_o),
        .tcdm         (tcdm),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .perf_stall_o (perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0, cyc = 0, n_rv = 0, n_wr = 0;
    bit act = 0, m_rd = 0, wv = 0, prev_stall = 0;
    int m_cnt = 0, m_grants = 0, m_resps = 0, m_outst = 0, done_at = NEVER, last_due = 0, perf_m = 0;
    logic [AW-1:0]  m_base = '0, m_stride = '0, prev_add = '0;
    logic [DW-1:0]  prev_data = '0;
    logic [BEW-1:0] prev_be = '0;
    int due_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock of the model: drive at negedge, check after settling, update on posedge
    task automatic step(input int gp, input int dmin, input int dmax, input bit clr, input bit st);
        bit req_exp, g, rv, busy_exp, stall;
        logic [AW-1:0] a_exp;
        logic [DW-1:0] rd;
        int due;
        @(negedge clk_i);
        clear_i = clr;
        start_i = st || (act && $urandom_range(0, 9) == 0);
        if (!wv && $urandom_range(0, 99) < 70) begin
            wv = 1;
            wdata_i = {$urandom, $urandom, $urandom, $urandom};
            wbe_i = BEW'($urandom);
        end
        wdata_valid_i = wv;
        #1;
        req_exp = act && m_grants < m_cnt && m_outst < MO && (m_rd || wv);
        a_exp = (m_base + m_stride * AW'(m_grants)) & ~AW'(3);
        check("req", tcdm.req, req_exp);
        if (req_exp) begin
            check("add", tcdm.add, a_exp);
            check("wen", tcdm.wen, m_rd);
            if (!m_rd) begin
                check("data", tcdm.data, wdata_i);
                check("be", tcdm.be, wbe_i);
            end
            if (prev_stall) begin
                check("hold_add", tcdm.add, prev_add);
                if (!m_rd) begin
                    check("hold_data", tcdm.data, prev_data);
                    check("hold_be", tcdm.be, prev_be);
                end
            end
        end
        g = !clr && $urandom_range(1, 100) <= gp;
        rv = due_q.size() != 0 && due_q[0] == cyc;
        rd = {$urandom, $urandom, $urandom, $urandom};
        tcdm.gnt = g;
        tcdm.r_valid = rv;
        tcdm.r_data = rd;
        #1;
        busy_exp = act && m_cnt != 0 && cyc < done_at;
        check("busy", busy_o, busy_exp);
        check("done", done_o, act && cyc == done_at);
        check("rvalid", rvalid_o, rv && busy_exp && m_rd);
        if (rv && busy_exp && m_rd) check("rdata", rdata_o, rd);
        check("wready", wdata_ready_o, req_exp && g && !m_rd);
        check("perf", perf_stall_o, PERF ? CNT_W'(perf_m) : '0);
        if (rvalid_o) n_rv++;
        if (wdata_ready_o) n_wr++;
        stall = act && m_grants < m_cnt && ((req_exp && !g) || (!req_exp && m_outst == MO));
        prev_add = tcdm.add;
        prev_data = tcdm.data;
        prev_be = tcdm.be;
        @(posedge clk_i);
        if (rv) void'(due_q.pop_front());
        if (clr) begin
            act = 0;
            m_outst = 0;
            perf_m = 0;
            prev_stall = 0;
        end else if (st && !act) begin
            act = 1;
            m_cnt = int'(cfg_count_i);
            m_base = cfg_base_i;
            m_stride = cfg_stride_i;
            m_rd = cfg_wen_i;
            m_grants = 0;
            m_resps = 0;
            m_outst = 0;
            perf_m = 0;
            prev_stall = 0;
            done_at = cfg_count_i == '0 ? cyc + 1 : NEVER;
        end else begin
            if (stall && perf_m < 65535) perf_m++;
            if (rv && busy_exp) begin
                m_resps++;
                m_outst--;
                if (m_resps == m_cnt) done_at = cyc + 2;
            end
            if (req_exp && g) begin
                m_grants++;
                m_outst++;
                due = cyc + $urandom_range(dmin, dmax);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                due_q.push_back(due);
                if (!m_rd) wv = 0;
            end
            prev_stall = req_exp && !g;
            if (act && cyc == done_at) act = 0;
        end
        cyc++;
    endtask

    task automatic run_seq(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int cnt,
                           input bit rd, input int gp, input int dmin, input int dmax);
        #1;
        cfg_base_i = base;
        cfg_stride_i = stride;
        cfg_count_i = CNT_W'(cnt);
        cfg_wen_i = rd;
        n_rv = 0;
        n_wr = 0;
        step(gp, dmin, dmax, 0, 1);
        #1;
        cfg_base_i = $urandom;
        cfg_stride_i = $urandom;
        cfg_count_i = CNT_W'($urandom);
        cfg_wen_i = $urandom_range(0, 1) == 1;
        for (int i = 0; i < 3000 && act; i++) step(gp, dmin, dmax, 0, 0);
        check("seq_timeout", act, 1'b0);
        check("n_rvalid", n_rv, rd ? cnt : 0);
        check("n_wready", n_wr, rd ? 0 : cnt);
    endtask

    initial begin
        clear_i = 1;
        start_i = 0;
        cfg_base_i = '0;
        cfg_stride_i = '0;
        cfg_count_i = '0;
        cfg_wen_i = 0;
        wdata_i = '0;
        wbe_i = '0;
        wdata_valid_i = 0;
        tcdm.gnt = 0;
        tcdm.r_valid = 0;
        tcdm.r_data = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req", tcdm.req, 1'b0);
        check("rst_add", tcdm.add, '0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_wready", wdata_ready_o, 1'b0);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_perf", perf_stall_o, '0);
        clear_i = 0;

        run_seq(32'h100, 32'h10, 4, 1, 100, 1, 1);
        run_seq(32'h2000, 32'h40, 3, 0, 50, 1, 3);
        run_seq(32'h400, 32'h20, 6, 1, 100, 5, 5);
        run_seq(32'h800, 32'h10, 0, 1, 100, 1, 1);
        run_seq(32'hFFFF_FFF0, 32'h10, 2, 1, 100, 1, 2);
        run_seq(32'h1000, 32'hFFFF_FFE0, 5, 0, 70, 1, 4);

        #1;
        cfg_base_i = 32'h3000;
        cfg_stride_i = 32'h8;
        cfg_count_i = 16'd8;
        cfg_wen_i = 1;
        step(100, 8, 8, 0, 1);
        for (int i = 0; i < 50 && m_outst < MO; i++) step(100, 8, 8, 0, 0);
        check("outst_reached", m_outst, MO);
        step(100, 8, 8, 1, 0);
        for (int i = 0; i < 50 && due_q.size() != 0; i++) step(100, 8, 8, 0, 0);
        check("drain_timeout", due_q.size(), 0);
        check("clr_add", tcdm.add, '0);
        run_seq(32'h3000, 32'h8, 3, 1, 100, 1, 2);

        for (int k = 0; k < 12; k++)
            run_seq($urandom, $urandom, $urandom_range(1, 10), $urandom_range(0, 1) == 1,
                    $urandom_range(30, 100), 1, $urandom_range(1, 6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
